mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/core_pkg.sv | 25 ++
 rtl/arb_id_fifo.sv | 69 ++++++
 rtl/mem_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_arbiter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared types and widths for the memory arbiter.
package core_pkg;

    localparam int Xlen     = 32;
    localparam int MaskBits = Xlen / 8;

    // Requester identity, also the payload of the in-order response ID queue.
    typedef enum logic {
        ArbInst = 1'b0,
        ArbData = 1'b1
    } arb_id_e;

    // Arbiter grant state.
    typedef enum logic [1:0] {
        Idle    = 2'd0,
        GntInst = 2'd1,
        GntData = 2'd2
    } arb_state_e;

    // A request with an all-zero byte mask is a read and expects a response.
    function automatic logic is_read(input logic [MaskBits-1:0] wmask);
        return wmask == '0;
    endfunction

endpackage

// File: rtl/arb_id_fifo.sv
// In-order queue of requester IDs for outstanding reads.
// Depth must be a power of two so the pointers wrap naturally.
module arb_id_fifo
    import core_pkg::*;
#(
    parameter int Depth = 2
) (
    input  logic    clk_i,
    input  logic    rst_i,
    input  logic    push_i,
    input  arb_id_e data_i,
    input  logic    pop_i,
    output arb_id_e data_o,
    output logic    full_o,
    output logic    empty_o
);

    localparam int PtrW = $clog2(Depth);
    localparam int CntW = $clog2(Depth + 1);

    arb_id_e           mem_q [Depth];
    arb_id_e           mem_d [Depth];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic              push_ok;
    logic              pop_ok;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign data_o  = mem_q[rd_ptr_q];
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Next pointers, storage and occupancy; a simultaneous push and pop leaves the count alone.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = wr_ptr_q + PtrW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer/count registers with synchronous reset; storage needs no reset.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (fetch / LSU) arbiter onto a single memory port with
// in-order read response routing.
// Build option: MEM_ARBITER_RR_EN selects round-robin on contention;
// without it the LSU always wins contention.
//
// state   | meaning
// --------+-----------------------------------------------------------
// Idle    | combinational arbitration, winner forwarded with no latency
// GntInst | fetch request stalled by memory; only fetch is forwarded
// GntData | LSU request stalled by memory; only LSU is forwarded
module mem_arbiter
    import core_pkg::*;
#(
    parameter int Depth = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,

    input  logic                inst_valid_i,
    output logic                inst_ready_o,
    input  logic [Xlen-1:0]     inst_addr_i,
    input  logic [Xlen-1:0]     inst_wdata_i,
    input  logic [MaskBits-1:0] inst_wmask_i,
    output logic [Xlen-1:0]     inst_rdata_o,
    output logic                inst_rvalid_o,

    input  logic                data_valid_i,
    output logic                data_ready_o,
    input  logic [Xlen-1:0]     data_addr_i,
    input  logic [Xlen-1:0]     data_wdata_i,
    input  logic [MaskBits-1:0] data_wmask_i,
    output logic [Xlen-1:0]     data_rdata_o,
    output logic                data_rvalid_o,

    output logic                mem_valid_o,
    input  logic                mem_ready_i,
    output logic [Xlen-1:0]     mem_addr_o,
    output logic [Xlen-1:0]     mem_wdata_o,
    output logic [MaskBits-1:0] mem_wmask_o,
    input  logic [Xlen-1:0]     mem_rdata_i,
    input  logic                mem_rvalid_i
);

    arb_state_e state_q, state_d;
    arb_id_e    winner;
    arb_id_e    sel;
    arb_id_e    head_id;
    logic       sel_valid;
    logic       xfer;
    logic       push;
    logic       pop;
    logic       q_full;
    logic       q_empty;

`ifdef MEM_ARBITER_RR_EN
    arb_id_e    last_grant_q, last_grant_d;
`endif

    // Idle-state winner: the only requester, or the contention policy.
    always_comb begin
        winner = data_valid_i ? ArbData : ArbInst;
`ifdef MEM_ARBITER_RR_EN
        if (inst_valid_i && data_valid_i) begin
            winner = (last_grant_q == ArbData) ? ArbInst : ArbData;
        end
`endif
    end

    // Grant selection, payload mux, handshake and next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            GntInst: sel = ArbInst;
            GntData: sel = ArbData;
            default: sel = winner;
        endcase

        sel_valid   = (sel == ArbData) ? data_valid_i : inst_valid_i;
        mem_addr_o  = (sel == ArbData) ? data_addr_i  : inst_addr_i;
        mem_wdata_o = (sel == ArbData) ? data_wdata_i : inst_wdata_i;
        mem_wmask_o = (sel == ArbData) ? data_wmask_i : inst_wmask_i;

        // A full ID queue blocks all new transfers, even if a response pops this cycle.
        mem_valid_o  = sel_valid && !q_full && !rst_i;
        xfer         = mem_valid_o && mem_ready_i;
        inst_ready_o = xfer && (sel == ArbInst);
        data_ready_o = xfer && (sel == ArbData);

        case (state_q)
            Idle: begin
                if (sel_valid && !xfer) begin
                    state_d = (sel == ArbData) ? GntData : GntInst;
                end
            end
            GntInst, GntData: begin
                if (xfer) begin
                    state_d = Idle;
                end
            end
            default: state_d = Idle;
        endcase
    end

    // Read transfers record the requester; responses pop it and route rvalid.
    always_comb begin
        push          = xfer && is_read(mem_wmask_o);
        pop           = mem_rvalid_i && !q_empty && !rst_i;
        inst_rvalid_o = pop && (head_id == ArbInst);
        data_rvalid_o = pop && (head_id == ArbData);
    end

    assign inst_rdata_o = mem_rdata_i;
    assign data_rdata_o = mem_rdata_i;

    arb_id_fifo #(
        .Depth (Depth)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .data_i  (sel),
        .pop_i   (pop),
        .data_o  (head_id),
        .full_o  (q_full),
        .empty_o (q_empty)
    );

    // Grant state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= Idle;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef MEM_ARBITER_RR_EN
    // Last granted requester, updated on every transfer.
    always_comb begin
        last_grant_d = xfer ? sel : last_grant_q;
    end

    // Last-grant register; reset favours the LSU on the first contention.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_grant_q <= ArbInst;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter (Depth = 2).
module tb_mem_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        inst_valid_i, inst_ready_o, inst_rvalid_o;
    logic [31:0] inst_addr_i, inst_wdata_i, inst_rdata_o;
    logic [3:0]  inst_wmask_i;
    logic        data_valid_i, data_ready_o, data_rvalid_o;
    logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
    logic [3:0]  data_wmask_i;
    logic        mem_valid_o, mem_ready_i, mem_rvalid_i;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic [3:0]  mem_wmask_o;

    always #5 clk_i = ~clk_i;

    mem_arbiter #(.Depth(2)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .inst_valid_i  (inst_valid_i),
        .inst_ready_o  (inst_ready_o),
        .inst_addr_i   (inst_addr_i),
        .inst_wdata_i  (inst_wdata_i),
        .inst_wmask_i  (inst_wmask_i),
        .inst_rdata_o  (inst_rdata_o),
        .inst_rvalid_o (inst_rvalid_o),
        .data_valid_i  (data_valid_i),
        .data_ready_o  (data_ready_o),
        .data_addr_i   (data_addr_i),
        .data_wdata_i  (data_wdata_i),
        .data_wmask_i  (data_wmask_i),
        .data_rdata_o  (data_rdata_o),
        .data_rvalid_o (data_rvalid_o),
        .mem_valid_o   (mem_valid_o),
        .mem_ready_i   (mem_ready_i),
        .mem_addr_o    (mem_addr_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_wmask_o   (mem_wmask_o),
        .mem_rdata_i   (mem_rdata_i),
        .mem_rvalid_i  (mem_rvalid_i)
    );

    // One cycle of stimulus and the expected combinational outputs.
    // gd: expected granted requester (1 = data); payload checked only when mv.
    typedef struct {
        logic        rst;
        logic        iv;
        logic [31:0] ia;
        logic [3:0]  im;
        logic        dv;
        logic [31:0] da;
        logic [3:0]  dm;
        logic        mr;
        logic        rv;
        logic [31:0] rd;
        logic        mv;
        logic        gd;
        logic        ir;
        logic        dr;
        logic        irv;
        logic        drv;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t v(
        input logic rst, input logic iv, input logic [31:0] ia, input logic [3:0] im,
        input logic dv, input logic [31:0] da, input logic [3:0] dm,
        input logic mr, input logic rv, input logic [31:0] rd,
        input logic mv, input logic gd, input logic ir, input logic dr,
        input logic irv, input logic drv);
        vec_t t;
        t.rst = rst; t.iv = iv; t.ia = ia; t.im = im;
        t.dv = dv; t.da = da; t.dm = dm;
        t.mr = mr; t.rv = rv; t.rd = rd;
        t.mv = mv; t.gd = gd; t.ir = ir; t.dr = dr; t.irv = irv; t.drv = drv;
        return t;
    endfunction

    task automatic chk(input string name, input int row, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s row %0d got %h expected %h", name, row, got, exp);
        end
    endtask

    task automatic apply(input vec_t t, input int row);
        logic [31:0] exp_addr, exp_wdata;
        logic [3:0]  exp_wmask;
        @(negedge clk_i);
        rst_i        = t.rst;
        inst_valid_i = t.iv;
        inst_addr_i  = t.ia;
        inst_wmask_i = t.im;
        inst_wdata_i = ~t.ia;
        data_valid_i = t.dv;
        data_addr_i  = t.da;
        data_wmask_i = t.dm;
        data_wdata_i = t.da ^ 32'h5555_0000;
        mem_ready_i  = t.mr;
        mem_rvalid_i = t.rv;
        mem_rdata_i  = t.rd;
        #1;
        exp_addr  = t.gd ? t.da : t.ia;
        exp_wdata = t.gd ? (t.da ^ 32'h5555_0000) : ~t.ia;
        exp_wmask = t.gd ? t.dm : t.im;
        chk("mem_valid",   row, {31'd0, mem_valid_o},   {31'd0, t.mv});
        chk("inst_ready",  row, {31'd0, inst_ready_o},  {31'd0, t.ir});
        chk("data_ready",  row, {31'd0, data_ready_o},  {31'd0, t.dr});
        chk("inst_rvalid", row, {31'd0, inst_rvalid_o}, {31'd0, t.irv});
        chk("data_rvalid", row, {31'd0, data_rvalid_o}, {31'd0, t.drv});
        chk("inst_rdata",  row, inst_rdata_o, t.rd);
        chk("data_rdata",  row, data_rdata_o, t.rd);
        if (t.mv) begin
            chk("mem_addr",  row, mem_addr_o,  exp_addr);
            chk("mem_wdata", row, mem_wdata_o, exp_wdata);
            chk("mem_wmask", row, {28'd0, mem_wmask_o}, {28'd0, exp_wmask});
        end
    endtask

    initial begin
        rst_i = 1'b1;
        inst_valid_i = 1'b0; inst_addr_i = '0; inst_wdata_i = '0; inst_wmask_i = '0;
        data_valid_i = 1'b0; data_addr_i = '0; data_wdata_i = '0; data_wmask_i = '0;
        mem_ready_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;

        // reset holds every handshake low
        tbl.push_back(v(1,1,32'h100,0,1,32'h200,0,1,1,32'h0,        0,0,0,0,0,0));
        // single fetch read, response two cycles later
        tbl.push_back(v(0,1,32'h100,0,0,32'h0,0,1,0,32'h0,          1,0,1,0,0,0));
        tbl.push_back(v(0,0,32'h0,0,0,32'h0,0,1,0,32'h0,            0,0,0,0,0,0));
        tbl.push_back(v(0,0,32'h0,0,0,32'h0,0,1,1,32'hDEADBEEF,     0,0,0,0,1,0));
        // contention: data first, inst next; same-cycle push and pop
        tbl.push_back(v(0,1,32'h100,0,1,32'h200,0,1,0,32'h0,        1,1,0,1,0,0));
        tbl.push_back(v(0,1,32'h100,0,0,32'h0,0,1,1,32'h00005A5A,   1,0,1,0,0,1));
        tbl.push_back(v(0,0,32'h0,0,0,32'h0,0,1,1,32'h12345678,     0,0,0,0,1,0));
        // three back-to-back write contentions
        tbl.push_back(v(0,1,32'h140,4'h3,1,32'h240,4'hF,1,0,32'h0,  1,1,0,1,0,0));
`ifdef MEM_ARBITER_RR_EN
        tbl.push_back(v(0,1,32'h140,4'h3,1,32'h240,4'hF,1,0,32'h0,  1,0,1,0,0,0));
`else
        tbl.push_back(v(0,1,32'h140,4'h3,1,32'h240,4'hF,1,0,32'h0,  1,1,0,1,0,0));
`endif
        tbl.push_back(v(0,1,32'h140,4'h3,1,32'h240,4'hF,1,0,32'h0,  1,1,0,1,0,0));
        tbl.push_back(v(0,1,32'h140,4'h3,0,32'h0,0,1,0,32'h0,       1,0,1,0,0,0));
        // fetch stalled by memory: grant locked to fetch
        tbl.push_back(v(0,1,32'h180,0,0,32'h0,0,0,0,32'h0,          1,0,0,0,0,0));
        tbl.push_back(v(0,1,32'h180,0,1,32'h280,0,0,0,32'h0,        1,0,0,0,0,0));
        tbl.push_back(v(0,1,32'h180,0,1,32'h280,0,0,0,32'h0,        1,0,0,0,0,0));
        tbl.push_back(v(0,1,32'h180,0,1,32'h280,0,1,0,32'h0,        1,0,1,0,0,0));
        tbl.push_back(v(0,0,32'h0,0,1,32'h280,0,1,0,32'h0,          1,1,0,1,0,0));
        // queue full: third read stalls until a response frees a slot
        tbl.push_back(v(0,1,32'h1C0,0,0,32'h0,0,1,0,32'h0,          0,0,0,0,0,0));
        tbl.push_back(v(0,1,32'h1C0,0,0,32'h0,0,1,1,32'h11111111,   0,0,0,0,1,0));
        tbl.push_back(v(0,1,32'h1C0,0,0,32'h0,0,1,0,32'h0,          1,0,1,0,0,0));
        tbl.push_back(v(0,0,32'h0,0,0,32'h0,0,1,1,32'h22222222,     0,0,0,0,0,1));
        tbl.push_back(v(0,0,32'h0,0,0,32'h0,0,1,1,32'h33333333,     0,0,0,0,1,0));
        // response with empty queue is dropped
        tbl.push_back(v(0,0,32'h0,0,0,32'h0,0,1,1,32'h44444444,     0,0,0,0,0,0));
        // data write does not enqueue; following fetch read does
        tbl.push_back(v(0,0,32'h0,0,1,32'h300,4'hF,1,0,32'h0,       1,1,0,1,0,0));
        tbl.push_back(v(0,1,32'h104,0,0,32'h0,0,1,0,32'h0,          1,0,1,0,0,0));
        tbl.push_back(v(0,0,32'h0,0,0,32'h0,0,1,1,32'h55555555,     0,0,0,0,1,0));
        tbl.push_back(v(0,0,32'h0,0,0,32'h0,0,1,1,32'h66666666,     0,0,0,0,0,0));
        // reset with two reads outstanding discards them
        tbl.push_back(v(0,1,32'h108,0,0,32'h0,0,1,0,32'h0,          1,0,1,0,0,0));
        tbl.push_back(v(0,0,32'h0,0,1,32'h308,0,1,0,32'h0,          1,1,0,1,0,0));
        tbl.push_back(v(1,1,32'h10C,0,1,32'h30C,0,1,1,32'h00000BAD, 0,0,0,0,0,0));
        tbl.push_back(v(0,0,32'h0,0,0,32'h0,0,1,1,32'h77777777,     0,0,0,0,0,0));
        tbl.push_back(v(0,0,32'h0,0,0,32'h0,0,1,1,32'h88888888,     0,0,0,0,0,0));
        tbl.push_back(v(0,1,32'h10C,0,0,32'h0,0,1,0,32'h0,          1,0,1,0,0,0));
        tbl.push_back(v(0,0,32'h0,0,0,32'h0,0,1,1,32'h99999999,     0,0,0,0,1,0));

        foreach (tbl[i]) apply(tbl[i], i);

        // Pointer wrap: alternating single reads, each response arriving with the
        // next request, so the queue cycles through every slot several times.
        begin
            logic who, prev;
            int   base;
            prev = 1'b0;
            base = tbl.size();
            for (int i = 0; i < 8; i++) begin
                who = i[0];
                apply(v(0, !who, 32'h400 + 32'(i*4), 0, who, 32'h500 + 32'(i*4), 0,
                        1, (i > 0), 32'hA0000000 + 32'(i),
                        1, who, !who, who, (i > 0) && !prev, (i > 0) && prev),
                      base + i);
                prev = who;
            end
            apply(v(0,0,32'h0,0,0,32'h0,0,1,1,32'hB0000000, 0,0,0,0,!prev,prev), base + 8);
            apply(v(0,0,32'h0,0,0,32'h0,0,1,1,32'hC0000000, 0,0,0,0,0,0),        base + 9);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
